// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end and its decoder.
package rom_fetch_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;

    // Opcode nibbles at or above this value carry an immediate byte.
    localparam logic [3:0] LONG_MIN = 4'hC;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        HOLD      = 2'd2
    } fetch_state_e;

    function automatic logic is_long_op(input logic [3:0] op);
        return op >= LONG_MIN;
    endfunction

endpackage

// File: rtl/rom_fetch_if.sv
// ROM read port plus instruction bundle handshake between fetch and decode.
interface rom_fetch_if;
    import rom_fetch_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        instr;
    logic [3:0]        oprnd;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output rom_addr,
        input  rom_data,
        output instr_valid,
        input  instr_ready,
        output instr,
        output oprnd,
        output imm,
        output instr_pc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  oprnd,
        input  imm,
        input  instr_pc
    );

endinterface

// File: rtl/rom_fetch_pc_counter.sv
// Program counter: async clear, synchronous load with priority, increment enable.
module pc_counter #(
    parameter int unsigned WIDTH     = 12,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_pc
);

    logic [WIDTH-1:0] r_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_VAL;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + WIDTH'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/rom_fetch.sv
// Fetch front end: reads opcode and optional immediate from ROM, presents one
// registered instruction bundle at a time over valid/ready.
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_pc_load,
    input  logic [ADDR_W-1:0] i_pc_load_addr,
    rom_fetch_if.master       io_fetch
);

    fetch_state_e      r_state;
    logic              r_valid;
    logic [3:0]        r_instr;
    logic [3:0]        r_oprnd;
    logic [DATA_W-1:0] r_imm;
    logic [ADDR_W-1:0] r_instr_pc;

    logic [ADDR_W-1:0] w_pc;
    logic              w_inc;

    assign w_inc = i_enable && ((r_state == FETCH_OP) || (r_state == FETCH_IMM));

    pc_counter #(
        .WIDTH     (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (i_pc_load),
        .i_load_val (i_pc_load_addr),
        .i_inc      (w_inc),
        .o_pc       (w_pc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= FETCH_OP;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_oprnd    <= '0;
            r_imm      <= '0;
            r_instr_pc <= '0;
        end else if (i_pc_load) begin
            // A jump drops any partial or undelivered bundle.
            r_state <= FETCH_OP;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                FETCH_OP: begin
                    if (i_enable) begin
                        r_instr    <= io_fetch.rom_data[7:4];
                        r_oprnd    <= io_fetch.rom_data[3:0];
                        r_imm      <= '0;
                        r_instr_pc <= w_pc;
                        if (is_long_op(io_fetch.rom_data[7:4])) begin
                            r_state <= FETCH_IMM;
                        end else begin
                            r_state <= HOLD;
                            r_valid <= 1'b1;
                        end
                    end
                end
                FETCH_IMM: begin
                    if (i_enable) begin
                        r_imm   <= io_fetch.rom_data;
                        r_state <= HOLD;
                        r_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (io_fetch.instr_ready) begin
                        r_state <= FETCH_OP;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= FETCH_OP;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_fetch.rom_addr    = w_pc;
    assign io_fetch.instr_valid = r_valid;
    assign io_fetch.instr       = r_instr;
    assign io_fetch.oprnd       = r_oprnd;
    assign io_fetch.imm         = r_imm;
    assign io_fetch.instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_rom_fetch.sv
// Directed bench for rom_fetch with a behavioural 4K x 8 ROM.
module tb_rom_fetch;
    import rom_fetch_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_addr;
    logic [7:0]        rom [4096];

    int n_checks;
    int n_fail;

    rom_fetch_if u_if ();

    rom_fetch u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_pc_load      (pc_load),
        .i_pc_load_addr (pc_load_addr),
        .io_fetch       (u_if)
    );

    assign u_if.rom_data = rom[u_if.rom_addr];

    // {valid, instr, oprnd, imm, instr_pc, rom_addr}
    logic [40:0] obs;
    assign obs = {u_if.instr_valid, u_if.instr, u_if.oprnd, u_if.imm, u_if.instr_pc,
                  u_if.rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; pc_load = 1'b0; pc_load_addr = '0;
        u_if.instr_ready = 1'b0;
        step(); step();
        n_checks++;
        if (obs !== {1'b0, 4'h0, 4'h0, 8'h00, 12'h000, 12'h000}) begin
            n_fail++; $display("FAIL reset: got %h want %h", obs, 41'h0);
        end
    endtask

    task automatic test_one_byte();
        rst_n = 1'b1; enable = 1'b1; u_if.instr_ready = 1'b1;
        step();
        n_checks++;
        if (obs !== {1'b1, 4'h1, 4'h5, 8'h00, 12'h000, 12'h001}) begin
            n_fail++; $display("FAIL one_byte: got %h want %h", obs,
                               {1'b1, 4'h1, 4'h5, 8'h00, 12'h000, 12'h001});
        end
    endtask

    task automatic test_two_byte();
        step();
        n_checks++;
        if (obs[40] !== 1'b0 || obs[11:0] !== 12'h001) begin
            n_fail++; $display("FAIL two_byte_ack: got %h", obs);
        end
        step();
        n_checks++;
        if (obs[40] !== 1'b0 || obs[11:0] !== 12'h002) begin
            n_fail++; $display("FAIL two_byte_imm_fetch: got %h", obs);
        end
        step();
        n_checks++;
        if (obs !== {1'b1, 4'hC, 4'h3, 8'hA7, 12'h001, 12'h003}) begin
            n_fail++; $display("FAIL two_byte_bundle: got %h want %h", obs,
                               {1'b1, 4'hC, 4'h3, 8'hA7, 12'h001, 12'h003});
        end
    endtask

    task automatic test_ready_stall();
        u_if.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (obs !== {1'b1, 4'hC, 4'h3, 8'hA7, 12'h001, 12'h003}) begin
                n_fail++; $display("FAIL ready_stall[%0d]: got %h want %h", i, obs,
                                   {1'b1, 4'hC, 4'h3, 8'hA7, 12'h001, 12'h003});
            end
        end
        u_if.instr_ready = 1'b1;
        step();
        n_checks++;
        if (obs[40] !== 1'b0 || obs[11:0] !== 12'h003) begin
            n_fail++; $display("FAIL ready_accept: got %h", obs);
        end
    endtask

    task automatic test_enable_stall();
        step();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs[40] !== 1'b0 || obs[11:0] !== 12'h004) begin
                n_fail++; $display("FAIL enable_stall[%0d]: got %h want addr 004", i, obs);
            end
        end
        enable = 1'b1;
        step();
        n_checks++;
        if (obs !== {1'b1, 4'hD, 4'h4, 8'h5A, 12'h003, 12'h005}) begin
            n_fail++; $display("FAIL enable_resume: got %h want %h", obs,
                               {1'b1, 4'hD, 4'h4, 8'h5A, 12'h003, 12'h005});
        end
        step();
    endtask

    task automatic test_jump();
        step();
        pc_load = 1'b1; pc_load_addr = 12'h0FF;
        step();
        pc_load = 1'b0;
        n_checks++;
        if (obs[40] !== 1'b0 || obs[11:0] !== 12'h0FF) begin
            n_fail++; $display("FAIL jump_drop: got %h want valid 0 addr 0ff", obs);
        end
        step();
        n_checks++;
        if (obs !== {1'b1, 4'h2, 4'h7, 8'h00, 12'h0FF, 12'h100}) begin
            n_fail++; $display("FAIL jump_bundle: got %h want %h", obs,
                               {1'b1, 4'h2, 4'h7, 8'h00, 12'h0FF, 12'h100});
        end
        step();
    endtask

    task automatic test_wrap();
        pc_load = 1'b1; pc_load_addr = 12'hFFF;
        step();
        pc_load = 1'b0;
        rom[0] = 8'h42;
        step();
        n_checks++;
        if (obs[40] !== 1'b0 || obs[11:0] !== 12'h000) begin
            n_fail++; $display("FAIL wrap_addr: got %h want addr 000", obs);
        end
        step();
        n_checks++;
        if (obs !== {1'b1, 4'hE, 4'h1, 8'h42, 12'hFFF, 12'h001}) begin
            n_fail++; $display("FAIL wrap_bundle: got %h want %h", obs,
                               {1'b1, 4'hE, 4'h1, 8'h42, 12'hFFF, 12'h001});
        end
        step();
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== {1'b0, 4'h0, 4'h0, 8'h00, 12'h000, 12'h000}) begin
            n_fail++; $display("FAIL async_reset: got %h want %h", obs, 41'h0);
        end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h000] = 8'h15;
        rom[12'h001] = 8'hC3;
        rom[12'h002] = 8'hA7;
        rom[12'h003] = 8'hD4;
        rom[12'h004] = 8'h5A;
        rom[12'h005] = 8'hE2;
        rom[12'h0FF] = 8'h27;
        rom[12'hFFF] = 8'hE1;
        test_reset();
        test_one_byte();
        test_two_byte();
        test_ready_stall();
        test_enable_stall();
        test_jump();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
